// File: rtl/sram_byte_fifo.sv
// 32-entry, 8-bit first-word-fall-through byte FIFO on a 32x8 dual-port distributed RAM.
// Port 1 writes synchronously, port 2 reads asynchronously to present the head byte.

module sram_32byte_dualport (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] a1,
  input  logic [7:0] d1_in,
  output logic [7:0] d1_out,
  input  logic [4:0] a2,
  output logic [7:0] d2_out
);

  logic [7:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) mem[a1] <= d1_in;
  end

  assign d1_out = mem[a1];
  assign d2_out = mem[a2];

endmodule

module sram_byte_fifo #(
  parameter int ALMOST_FULL_LEVEL = 28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       flush,
  output logic [5:0] count,
  output logic       almost_full,
  output logic       overflow
);

  localparam logic [5:0] AF_LEVEL = 6'(ALMOST_FULL_LEVEL);

  logic [4:0] wr_ptr;
  logic [4:0] rd_ptr;
  logic       full;
  logic       push;
  logic       pop;
  logic       we;
  logic [7:0] d1_unused;

  // Status flags come from registered count only; no path from the handshake inputs.
  assign full        = (count == 6'd32);
  assign in_ready    = !full;
  assign out_valid   = (count != 6'd0);
  assign almost_full = (count >= AF_LEVEL);

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign we   = push && !flush;

  sram_32byte_dualport u_ram (
    .clk    (clk),
    .we     (we),
    .a1     (wr_ptr),
    .d1_in  (in_data),
    .d1_out (d1_unused),
    .a2     (rd_ptr),
    .d2_out (out_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 5'd1;
      if (pop)  rd_ptr <= rd_ptr + 5'd1;
      if (push && !pop)      count <= count + 6'd1;
      else if (pop && !push) count <= count - 6'd1;
      if (in_valid && full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_byte_fifo.sv
// Directed self-checking bench for sram_byte_fifo: fill, drain, wrap, overflow, flush, async reset.

module tb_sram_byte_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       flush;
  logic [5:0] count;
  logic       almost_full;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sram_byte_fifo #(.ALMOST_FULL_LEVEL(28)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full got %b want 0", almost_full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    logic exp_af;
    for (int i = 0; i < 32; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_in_ready[%0d] got %b want 1", i, in_ready); end
      tick();
      exp_af = (i + 1 >= 28);
      n_checks++; if (count !== 6'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
      n_checks++; if (almost_full !== exp_af) begin n_fail++; $display("FAIL fill_almost_full[%0d] got %b want %b", i, almost_full, exp_af); end
    end
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow got %b want 0", overflow); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_out_valid got %b want 1", out_valid); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_out_valid[%0d] got %b want 1", i, out_valid); end
      n_checks++; if (out_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h want %h", i, out_data, 8'(i)); end
      tick();
      n_checks++; if (count !== 6'(31 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 31 - i); end
    end
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drain_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 100; j++) begin
      in_data = 8'(16 + j);
      n_checks++; if (out_data !== 8'(j)) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", j, out_data, 8'(j)); end
      tick();
      n_checks++; if (count !== 6'd16) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d want 16", j, count); end
    end
    in_valid = 1'b0;
    for (int k = 100; k < 116; k++) begin
      n_checks++; if (out_data !== 8'(k)) begin n_fail++; $display("FAIL wrap_tail[%0d] got %h want %h", k, out_data, 8'(k)); end
      tick();
    end
    out_ready = 1'b0;
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL wrap_final_count got %0d want 0", count); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 32; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      tick();
    end
    in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set[%0d] got %b want 1", i, overflow); end
      n_checks++; if (count !== 6'd32) begin n_fail++; $display("FAIL ovf_count[%0d] got %0d want 32", i, count); end
    end
    in_valid = 1'b0;
    tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    out_ready = 1'b1;
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL ovf_head got %h want 00", out_data); end
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_data !== 8'h01) begin n_fail++; $display("FAIL ovf_second got %h want 01", out_data); end
    n_checks++; if (count !== 6'd31) begin n_fail++; $display("FAIL ovf_pop_count got %0d want 31", count); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_overflow got %b want 0", overflow); end
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_flush_push();
    in_data = 8'hAA; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL flushpush_count got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flushpush_out_valid got %b want 0", out_valid); end
    in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL push55_out_valid got %b want 1", out_valid); end
    n_checks++; if (out_data !== 8'h55) begin n_fail++; $display("FAIL push55_data got %h want 55", out_data); end
    n_checks++; if (count !== 6'd1) begin n_fail++; $display("FAIL push55_count got %0d want 1", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL push55_pop_count got %0d want 0", count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h30 + i); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    n_checks++; if (count !== 6'd10) begin n_fail++; $display("FAIL pre_reset_count got %0d want 10", count); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL async_count got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_in_ready got %b want 1", in_ready); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL async_almost_full got %b want 0", almost_full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL async_overflow got %b want 0", overflow); end
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL post_reset_count got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_out_valid got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_overflow();
    test_flush_push();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
